trainer_adc_scheduler: RTL and testbench

Sequences the cycle trainer's single shared 12-bit ADC between two requesters: the temperature sensor channel and the pulse (heart-rate) sensor channel.
- A programmable timer raises periodic sampling requests; the pulse button raises on-demand pulse samples.
- A round-robin arbiter drives the ADC start/done handshake.
- Converted results are registered as the trainer's temperature byte, pulse sample and overheat LED.

---
 rtl/trainer_adc_scheduler_if.sv | 9 +
 rtl/trainer_adc_scheduler.sv | 83 ++++++++
 tb/tb_trainer_adc_scheduler.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/trainer_adc_scheduler_if.sv
// trainer_adc_scheduler_if: start/done handshake to the shared 12-bit ADC
interface trainer_adc_scheduler_if;
    logic        adc_start;
    logic        adc_channel;
    logic        adc_done;
    logic [11:0] adc_data;
    modport master(output adc_start, adc_channel, input adc_data, adc_done);
    modport slave(input adc_start, adc_channel, output adc_data, adc_done);
endinterface

// File: rtl/trainer_adc_scheduler.sv
// trainer_adc_scheduler: round-robin sharing of one ADC between temperature and pulse channels
module trainer_adc_scheduler #(
    parameter int SAMPLE_DIV  = 1000,
    parameter int ADC_TIMEOUT = 255,
    parameter int TEMP_LIMIT  = 200,
    parameter int TEMP_HYST   = 8
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           status,
    input  logic                           pulse_button,
    trainer_adc_scheduler_if.master        adc,
    output logic [7:0]                     temperature,
    output logic [11:0]                    pulse_sample,
    output logic                           pulse_valid,
    output logic                           led,
    output logic                           timeout_err
);
    localparam int CW = $clog2(SAMPLE_DIV);
    localparam int TW = $clog2(ADC_TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, START, CONVERT} state_t;
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tcnt;
    logic temp_pend, pulse_pend, last, btn_prev;
    logic tick, btn_edge, sel, done, expired, finish, clr_temp, clr_pulse;
    logic [7:0] t_new;

    assign tick      = status && cnt == CW'(SAMPLE_DIV - 1);
    assign btn_edge  = status && pulse_button && !btn_prev;
    assign sel       = (temp_pend && pulse_pend) ? !last : pulse_pend;
    assign done      = status && state == CONVERT && adc.adc_done;
    assign expired   = status && state == CONVERT && !adc.adc_done && tcnt == TW'(ADC_TIMEOUT - 1);
    assign finish    = done || expired;
    assign clr_temp  = finish && !adc.adc_channel;
    assign clr_pulse = finish && adc.adc_channel;
    assign t_new     = adc.adc_data[11:4];

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) state <= IDLE;
        else state <= state_nx;

    always_comb
        state_nx = !status ? IDLE
                 : state == IDLE ? ((temp_pend || pulse_pend) ? START : IDLE)
                 : state == START ? CONVERT
                 : state == CONVERT ? (finish ? IDLE : CONVERT)
                 : IDLE;

    always_comb adc.adc_start = state == START;

    // a new request in the same cycle as its completion keeps the flag set
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            cnt             <= '0;
            tcnt            <= '0;
            btn_prev        <= 1'b0;
            temp_pend       <= 1'b0;
            pulse_pend      <= 1'b0;
            last            <= 1'b1;
            adc.adc_channel <= 1'b0;
            temperature     <= '0;
            pulse_sample    <= '0;
            pulse_valid     <= 1'b0;
            led             <= 1'b0;
            timeout_err     <= 1'b0;
        end else begin
            cnt         <= (!status || tick) ? '0 : cnt + 1'b1;
            tcnt        <= state == CONVERT ? tcnt + 1'b1 : '0;
            btn_prev    <= pulse_button;
            temp_pend   <= status && (tick || (temp_pend && !clr_temp));
            pulse_pend  <= status && (tick || btn_edge || (pulse_pend && !clr_pulse));
            pulse_valid <= done && adc.adc_channel;
            if (status && state == IDLE && (temp_pend || pulse_pend)) adc.adc_channel <= sel;
            if (finish) last <= adc.adc_channel;
            if (expired) timeout_err <= 1'b1;
            if (done && adc.adc_channel) pulse_sample <= adc.adc_data;
            if (done && !adc.adc_channel) begin
                temperature <= t_new;
                led <= t_new >= 8'(TEMP_LIMIT) ? 1'b1 : t_new < 8'(TEMP_LIMIT - TEMP_HYST) ? 1'b0 : led;
            end
        end
endmodule

// File: tb/tb_trainer_adc_scheduler.sv
// tb_trainer_adc_scheduler: directed and random stimulus compared each cycle
// against a transaction-level model of the ADC scheduler.
module tb_trainer_adc_scheduler;
    localparam int DIV = 16, TO = 255, LIM = 200, HYS = 8;
    logic clock = 1'b0, reset_n = 1'b0, status = 1'b0, pulse_button = 1'b0;
    logic [7:0] temperature;
    logic [11:0] pulse_sample;
    logic pulse_valid, led, timeout_err;
    trainer_adc_scheduler_if adc();

    trainer_adc_scheduler #(.SAMPLE_DIV(DIV), .ADC_TIMEOUT(TO), .TEMP_LIMIT(LIM), .TEMP_HYST(HYS)) dut (
        .clock(clock), .reset_n(reset_n), .status(status), .pulse_button(pulse_button), .adc(adc),
        .temperature(temperature), .pulse_sample(pulse_sample), .pulse_valid(pulse_valid),
        .led(led), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    int errors = 0, checks = 0, cyc = 0;
    int run, age;
    bit tp, pp, bprev, job, last;
    bit [7:0] e_temp;
    bit [11:0] e_ps;
    bit e_pv, e_led, e_err, e_ch;
    int lat = 3, done_at = -1;
    bit hang_once, sync_done, rand_mode;
    bit [11:0] d_temp, d_pulse;
    int starts[$];
    int chans[$];
    int pv_cnt, err_cyc;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int ch_at(int i);
        return i < chans.size() ? chans[i] : -1;
    endfunction

    task automatic model_reset();
        run = 0; age = 0; tp = 0; pp = 0; bprev = 0; job = 0; last = 1;
        e_temp = 0; e_ps = 0; e_pv = 0; e_led = 0; e_err = 0; e_ch = 0; done_at = -1;
    endtask

    task automatic clear_log();
        starts.delete(); chans.delete(); pv_cnt = 0; err_cyc = -1;
    endtask

    // one job = START cycle (age 0) followed by conversion cycles (age >= 1)
    task automatic model_edge();
        bit tick, edg, fin;
        bit [7:0] t;
        tick = status && run % DIV == DIV - 1;
        edg = status && pulse_button && !bprev;
        run = status ? run + 1 : 0;
        bprev = pulse_button;
        e_pv = 0;
        fin = 0;
        if (!status) begin
            job = 0; tp = 0; pp = 0;
        end else begin
            if (!job) begin
                if (tp || pp) begin e_ch = (tp && pp) ? !last : pp; job = 1; age = 0; end
            end else if (age == 0) age = 1;
            else if (adc.adc_done) begin
                fin = 1;
                if (e_ch) begin e_ps = adc.adc_data; e_pv = 1; end
                else begin
                    t = adc.adc_data[11:4];
                    if (t >= LIM) e_led = 1;
                    else if (t < LIM - HYS) e_led = 0;
                    e_temp = t;
                end
            end else if (age == TO) begin fin = 1; e_err = 1; end
            else age++;
            if (fin) begin job = 0; last = e_ch; end
            tp = tick || (tp && !(fin && !e_ch));
            pp = tick || edg || (pp && !(fin && e_ch));
        end
    endtask

    task automatic compare();
        check("adc_start", adc.adc_start, job && age == 0);
        check("adc_channel", adc.adc_channel, e_ch);
        check("temperature", temperature, e_temp);
        check("pulse_sample", pulse_sample, e_ps);
        check("pulse_valid", pulse_valid, e_pv);
        check("led", led, e_led);
        check("timeout_err", timeout_err, e_err);
        if (adc.adc_start === 1'b1) begin starts.push_back(cyc); chans.push_back(int'(adc.adc_channel)); end
        if (pulse_valid === 1'b1) pv_cnt++;
        if (timeout_err === 1'b1 && err_cyc < 0) err_cyc = cyc;
    endtask

    task automatic drive();
        if (rand_mode) begin
            if ($urandom_range(0, status ? 150 : 5) == 0) status = !status;
            if ($urandom_range(0, 9) == 0) pulse_button = !pulse_button;
        end
        if (job && age == 0) begin
            if (rand_mode) begin
                lat = $urandom_range(1, 8);
                hang_once = $urandom_range(0, 24) == 0;
                d_temp = 12'($urandom);
                d_pulse = 12'($urandom);
            end
            done_at = hang_once ? -1 : cyc + lat;
            hang_once = 0;
        end
        adc.adc_done = cyc == done_at;
        adc.adc_data = e_ch ? d_pulse : d_temp;
        if (rand_mode && $urandom_range(0, 39) == 0) begin adc.adc_done = 1'b1; adc.adc_data = 12'($urandom); end
        if (sync_done && status && job && age > 0 && run % DIV == DIV - 1) begin
            adc.adc_done = 1'b1; pulse_button = 1'b1; sync_done = 0;
        end
    endtask

    task automatic step();
        @(posedge clock);
        if (reset_n) model_edge();
        cyc++;
        @(negedge clock);
        compare();
        drive();
    endtask

    task automatic do_reset();
        reset_n = 0; status = 0; pulse_button = 0; adc.adc_done = 0; adc.adc_data = 0;
        rand_mode = 0; hang_once = 0; sync_done = 0; lat = 3; d_temp = 0; d_pulse = 0;
        model_reset();
        clear_log();
        step();
        step();
        reset_n = 1;
    endtask

    initial begin
        int n;
        @(negedge clock);
        do_reset();
        check("reset adc_start", adc.adc_start, 0);
        check("reset led", led, 0);
        // first tick: temperature then pulse
        d_temp = 12'hC80; d_pulse = 12'hC80; status = 1;
        repeat (30) step();
        check("t1 start count", starts.size(), 2);
        check("t1 first channel", ch_at(0), 0);
        check("t1 second channel", ch_at(1), 1);
        check("t1 temperature", temperature, 8'hC8);
        check("t1 led", led, 1);
        check("t1 pulse_sample", pulse_sample, 12'hC80);
        check("t1 pulse_valid strobes", pv_cnt, 1);
        // hysteresis band
        d_temp = 12'hC00; repeat (16) step();
        check("t2 hold temperature", temperature, 8'hC0);
        check("t2 hold led", led, 1);
        d_temp = 12'hBF0; repeat (16) step();
        check("t2 clear temperature", temperature, 8'hBF);
        check("t2 clear led", led, 0);
        d_temp = 12'hC80; repeat (16) step();
        check("t2 set led", led, 1);
        // held button triggers one pulse sample
        do_reset();
        status = 1; pulse_button = 1; d_pulse = 12'h333;
        repeat (14) step();
        check("t3 start count", starts.size(), 1);
        check("t3 channel", ch_at(0), 1);
        check("t3 pulse_sample", pulse_sample, 12'h333);
        check("t3 pulse_valid strobes", pv_cnt, 1);
        check("t3 temperature", temperature, 0);
        repeat (6) step();
        pulse_button = 0;
        // timeout on a silent ADC
        do_reset();
        status = 1; hang_once = 1; d_pulse = 12'h123;
        for (int i = 0; i < 400 && err_cyc < 0; i++) step();
        check("t4 timeout seen", err_cyc >= 0, 1);
        check("t4 timeout latency", err_cyc - (starts.size() > 0 ? starts[0] : -1000), 256);
        check("t4 no data on timeout", temperature, 0);
        repeat (8) step();
        check("t4 next channel", ch_at(1), 1);
        check("t4 next start delay", (starts.size() > 1 ? starts[1] : -1000) - err_cyc, 1);
        repeat (40) step();
        check("t4 sticky", timeout_err, 1);
        // request set in the same cycle as a pulse completion
        do_reset();
        status = 1; pulse_button = 1; hang_once = 1; sync_done = 1; d_pulse = 12'h5A5; d_temp = 12'hC80;
        repeat (3) step();
        pulse_button = 0;
        repeat (27) step();
        check("t5 start count", starts.size(), 3);
        check("t5 order 0", ch_at(0), 1);
        check("t5 order 1", ch_at(1), 0);
        check("t5 order 2", ch_at(2), 1);
        check("t5 pulse_valid strobes", pv_cnt, 2);
        check("t5 pulse_sample", pulse_sample, 12'h5A5);
        // status dropped mid-conversion, then async reset mid-conversion
        do_reset();
        status = 1; lat = 10; d_temp = 12'hFFF; d_pulse = 12'hFFF;
        for (int i = 0; i < 40 && starts.size() == 0; i++) step();
        repeat (3) step();
        status = 0;
        repeat (15) step();
        check("t6 temperature held", temperature, 0);
        check("t6 pulse_sample held", pulse_sample, 0);
        check("t6 no pulse_valid", pv_cnt, 0);
        status = 1; lat = 2;
        repeat (30) step();
        check("t6 temperature", temperature, 8'hFF);
        check("t6 led", led, 1);
        n = starts.size();
        for (int i = 0; i < 40 && starts.size() == n; i++) step();
        step();
        reset_n = 0;
        #1;
        check("t6 rst temperature", temperature, 0);
        check("t6 rst pulse_sample", pulse_sample, 0);
        check("t6 rst led", led, 0);
        check("t6 rst adc_start", adc.adc_start, 0);
        check("t6 rst adc_channel", adc.adc_channel, 0);
        check("t6 rst timeout_err", timeout_err, 0);
        check("t6 rst pulse_valid", pulse_valid, 0);
        model_reset();
        repeat (3) step();
        // random traffic
        do_reset();
        rand_mode = 1; status = 1;
        repeat (6000) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
